// File: rtl/debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
//
// Cleans up the board pushbuttons and slide switches before they are handed to
// the GPIO logic. Every raw bit is brought into the clk domain by a two-flop
// synchroniser and then sampled on a shared slow tick. A bit's output changes
// only once DB_SAMPLES consecutive tick samples agree; mixed samples leave the
// output alone, so bounces and short glitches never reach the outputs.
//
// Build option:
//   DB_SIM_FAST_EN  when defined, the tick period is fixed at 10 clocks so the
//                   filter can be simulated quickly; otherwise the period is
//                   CLK_FREQ_HZ / DEBOUNCE_FREQ_HZ clocks.
//
// Ports:
//   clk        in   1    system clock, rising edge
//   reset      in   1    synchronous, active-high reset
//   pbtn_in    in   NPB  raw pushbuttons (asynchronous, bouncy)
//   switch_in  in   NSW  raw slide switches (asynchronous, bouncy)
//   pbtn_db    out  NPB  debounced pushbuttons (registered)
//   swtch_db   out  NSW  debounced switches (registered)
// -----------------------------------------------------------------------------
module debounce_filter #(
  parameter int CLK_FREQ_HZ      = 100000000,
  parameter int DEBOUNCE_FREQ_HZ = 1000,
  parameter int DB_SAMPLES       = 4,
  parameter int NPB              = 6,
  parameter int NSW              = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NPB-1:0] pbtn_in,
  input  logic [NSW-1:0] switch_in,
  output logic [NPB-1:0] pbtn_db,
  output logic [NSW-1:0] swtch_db
);

  // All buttons and switches are filtered as one flat vector; pushbuttons
  // occupy the low bits, switches the high bits.
  localparam int NB = NPB + NSW;

`ifdef DB_SIM_FAST_EN
  localparam int TICK_CNT = 10;
`else
  localparam int TICK_CNT = CLK_FREQ_HZ / DEBOUNCE_FREQ_HZ;
`endif

  // Keep the counter at least one bit wide even for a degenerate TICK_CNT of 1.
  localparam int CNT_W = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CNT - 1);

  logic [NB-1:0]         w_raw;
  logic [NB-1:0]         r_sync1;
  logic [NB-1:0]         r_sync2;
  logic [CNT_W-1:0]      r_tick_cnt;
  logic                  w_tick;
  logic [DB_SAMPLES-1:0] r_hist     [NB];
  logic [DB_SAMPLES-1:0] w_hist_nxt [NB];
  logic [NB-1:0]         r_db;
  logic [NB-1:0]         w_db_nxt;

  assign w_raw = {switch_in, pbtn_in};

  // Two-flop synchroniser for every raw input bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= {NB{1'b0}};
      r_sync2 <= {NB{1'b0}};
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The tick is decoded from the counter value so it is high for exactly the
  // one cycle whose closing edge also wraps the counter.
  assign w_tick = (r_tick_cnt == CNT_LAST);

  // Free-running tick counter, 0 .. TICK_CNT-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= {CNT_W{1'b0}};
    end else if (w_tick) begin
      r_tick_cnt <= {CNT_W{1'b0}};
    end else begin
      r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  // Next history and next output per bit. The output decision looks at the
  // history including the sample being taken on this tick, so a clean level
  // shows up on the same edge that completes the run of agreeing samples.
  always_comb begin
    w_db_nxt = r_db;
    for (int i = 0; i < NB; i++) begin
      w_hist_nxt[i] = r_hist[i];
      if (w_tick) begin
        w_hist_nxt[i] = {r_hist[i][DB_SAMPLES-2:0], r_sync2[i]};
        if (&w_hist_nxt[i]) begin
          w_db_nxt[i] = 1'b1;
        end else if (~|w_hist_nxt[i]) begin
          w_db_nxt[i] = 1'b0;
        end else begin
          // Mixed samples: hold the current output.
          w_db_nxt[i] = r_db[i];
        end
      end else begin
        w_db_nxt[i] = r_db[i];
      end
    end
  end

  // Sample histories and debounced outputs; reset discards partial history.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        r_hist[i] <= {DB_SAMPLES{1'b0}};
      end
      r_db <= {NB{1'b0}};
    end else begin
      for (int i = 0; i < NB; i++) begin
        r_hist[i] <= w_hist_nxt[i];
      end
      r_db <= w_db_nxt;
    end
  end

  assign pbtn_db  = r_db[NPB-1:0];
  assign swtch_db = r_db[NB-1:NPB];

endmodule

// File: tb/tb_debounce_filter.sv
// -----------------------------------------------------------------------------
// tb_debounce_filter
//
// Directed bench for debounce_filter. The DUT is scaled to a 10-clock tick
// (CLK_FREQ_HZ=100, DEBOUNCE_FREQ_HZ=10), which matches the fast-simulation
// tick, so expectations hold with or without DB_SIM_FAST_EN. Edge numbers in
// comments count rising edges after reset release (E1 = first edge with reset
// low); ticks close on E10, E20, ... An input driven after edge En is captured
// by the first synchroniser flop at E(n+1) and is visible to a tick two edges
// later.
// -----------------------------------------------------------------------------
module tb_debounce_filter;

  logic        clk;
  logic        reset;
  logic [5:0]  pbtn_in;
  logic [15:0] switch_in;
  logic [5:0]  pbtn_db;
  logic [15:0] swtch_db;

  int tests = 0;
  int fails = 0;

  debounce_filter #(
    .CLK_FREQ_HZ     (100),
    .DEBOUNCE_FREQ_HZ(10),
    .DB_SAMPLES      (4),
    .NPB             (6),
    .NSW             (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pbtn_in  (pbtn_in),
    .switch_in(switch_in),
    .pbtn_db  (pbtn_db),
    .swtch_db (swtch_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance until pbtn_db equals target (bounded); every cycle on the way the
  // output must be either its starting value or the target.
  task automatic wait_pb(input string tag, input logic [5:0] target, input int exp_n);
    logic [5:0] start;
    int n;
    start = pbtn_db;
    n = 0;
    while (pbtn_db !== target && n < 60) begin
      clk_n(1);
      n++;
      check({tag, "_no_intermediate"}, 32'(pbtn_db === start || pbtn_db === target), 32'd1);
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_n));
  endtask

  task automatic wait_sw(input string tag, input logic [15:0] target, input int exp_n);
    logic [15:0] start;
    int n;
    start = swtch_db;
    n = 0;
    while (swtch_db !== target && n < 60) begin
      clk_n(1);
      n++;
      check({tag, "_no_intermediate"}, 32'(swtch_db === start || swtch_db === target), 32'd1);
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    reset     = 1'b1;
    pbtn_in   = 6'h00;
    switch_in = 16'h0000;

    // 1. Reset for 3 clocks, then idle.
    clk_n(3);
    check("reset_pb", 32'(pbtn_db), 32'h00);
    check("reset_sw", 32'(swtch_db), 32'h0000);
    reset = 1'b0;
    clk_n(5);                                   // E5
    check("idle_pb", 32'(pbtn_db), 32'h00);
    check("idle_sw", 32'(swtch_db), 32'h0000);

    // 2. Clean step up: driven after E5, ticks E10..E40 -> output at E40,
    //    i.e. the 35th edge after the change.
    pbtn_in = 6'h3F;
    wait_pb("step_up", 6'h3F, 35);
    check("step_up_sw_quiet", 32'(swtch_db), 32'h0000);
    // Step down: driven after E40, ticks E50..E80 -> 40 edges.
    pbtn_in = 6'h00;
    wait_pb("step_down", 6'h00, 40);

    // 4. 25-clock glitch on switch_in[3] (after E80 .. after E105): only the
    //    E90 and E100 ticks see it high, so the output must stay low.
    switch_in = 16'h0008;
    clk_n(25);
    switch_in = 16'h0000;
    for (int i = 0; i < 50; i++) begin
      clk_n(1);
      check("glitch_sw", 32'(swtch_db), 32'h0000);
    end
    check("glitch_pb", 32'(pbtn_db), 32'h00);   // now at E155

    // 5. Bounce on pbtn_in[0]: 7-clock halves for 100 clocks starting high.
    //    Tick samples 1,0,0,1,1,0,1,1,0,0 never give four ones in a row.
    for (int i = 0; i < 100; i++) begin
      pbtn_in = ((i / 7) % 2 == 0) ? 6'h01 : 6'h00;
      clk_n(1);
      check("bounce_hold", 32'(pbtn_db), 32'h00);
    end
    // Settle high after E255: ticks E260..E290 all high -> rise at 35 edges.
    pbtn_in = 6'h01;
    wait_pb("settle", 6'h01, 35);
    for (int i = 0; i < 30; i++) begin
      clk_n(1);
      check("settle_stable", 32'(pbtn_db), 32'h01);
    end                                          // now at E320

    // 6. Switch pattern, then reset mid-operation.
    switch_in = 16'hA5A5;
    wait_sw("sw_pattern", 16'hA5A5, 40);
    reset = 1'b1;
    clk_n(1);
    check("midreset_sw", 32'(swtch_db), 32'h0000);
    check("midreset_pb", 32'(pbtn_db), 32'h00);
    reset = 1'b0;
    // Counter and synchronisers restart: ticks at 10..40 edges after release.
    wait_sw("sw_recover", 16'hA5A5, 40);
    check("pb_recover", 32'(pbtn_db), 32'h01);

    // Partial history discarded: start a fresh change, reset before it can
    // complete, then confirm the old level is not restored by stale samples.
    switch_in = 16'h0000;
    clk_n(25);
    reset = 1'b1;
    clk_n(1);
    reset = 1'b0;
    switch_in = 16'h00FF;
    wait_sw("sw_after_partial", 16'h00FF, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
